clk_seq_ctrl: RTL and testbench
===============================

Name: clk_seq_ctrl

Overview:
- Sequencing controller for the clock divider that produces clk10/clk20/clk40 from the fast clock.
- Drives the divider's reset and enable, and holds the divider in reset for a programmed time.
- Confirms the divided clocks are alive by watching clk40, and raises ready to the rest of the PHY.
- Reports a fault and shuts the divider down if clk40 stalls.
- Runs entirely in the fast clk domain.

Parameters:
- RST_CYCLES, 4: fast-clk cycles gen_rst is held high in RST_HOLD (1..255).
- SETTLE_EDGES, 2: clk40_mon edges (either polarity) required in SETTLE before ready (1..15).
- WDT_CYCLES, 64: max fast-clk cycles without a clk40_mon edge before fault (must exceed 20; ≤255).
- CNT_W, 8: width of the cycle counter.

Ports:
- clk  in  1  fast clock; also drives the divider.
- rst  in  1  synchronous active-high reset.
- start  in  1  level request to bring clocks up from OFF.
- stop  in  1  level request to shut clocks down; any state.
- restart  in  1  level request to re-run the reset/settle sequence from READY or FAULT.
- clk40_mon  in  1  divider clk40 output, sampled as data.
- gen_rst  out  1  reset to divider.
- gen_enb  out  1  enable to divider.
- ready  out  1  divided clocks verified running.
- fault  out  1  watchdog expired.
- busy  out  1  high in RST_HOLD or SETTLE.
- state  out  3  current state encoding.

Behaviour:
- Reset: rst is sampled on the clk rising edge. On reset:
  - state = OFF.
  - gen_rst = 1, gen_enb = 0, ready = 0, fault = 0, busy = 0.
  - Counter = 0, edge count = 0.
  - Monitor flops = 0.
- Reset mid-operation: rst in any state returns the block to OFF on the next edge.
- Outputs: all outputs are registered and decoded from the state register, so they change on the same edge as the state.
- Edge detect:
  - mon_q1 <= clk40_mon; mon_q2 <= mon_q1.
  - edge = mon_q1 ^ mon_q2.
  - An edge is therefore seen 2 cycles after the clk40_mon transition.
- Request priority, evaluated every cycle: stop > restart > start. A request that is illegal in the current state is ignored.
- States:
  - OFF (0):
    - gen_rst = 1, gen_enb = 0.
    - start & ~stop -> RST_HOLD.
  - RST_HOLD (1):
    - gen_rst = 1, gen_enb = 0, busy = 1.
    - Counter increments from 0. When counter == RST_CYCLES-1 -> SETTLE, with counter and edge count cleared.
    - Total RST_HOLD dwell = RST_CYCLES cycles.
  - SETTLE (2):
    - gen_rst = 0, gen_enb = 1, busy = 1.
    - Counter increments every cycle and clears on each edge.
    - Edge count increments on each edge.
    - Edge count reaching SETTLE_EDGES (on the edge cycle) -> READY.
    - Counter reaching WDT_CYCLES-1 with no edge that cycle -> FAULT.
  - READY (3):
    - gen_rst = 0, gen_enb = 1, ready = 1.
    - Counter clears on each edge.
    - Counter reaching WDT_CYCLES-1 with no edge -> FAULT.
    - restart -> RST_HOLD.
  - FAULT (4):
    - gen_rst = 1, gen_enb = 0, fault = 1 (sticky while in FAULT).
    - restart -> RST_HOLD.
    - start is ignored.
  - Any state: stop -> OFF.
- Simultaneous events:
  - stop beats everything, including watchdog expiry and the SETTLE->READY transition.
  - Watchdog expiry and restart in the same READY cycle: restart wins and goes to RST_HOLD.
  - Edge on the same cycle as the watchdog terminal count: the edge wins and the counter clears.
- Counter: CNT_W bits, saturating, never wraps. On every state change the counter clears and the edge count clears.
- Unused encodings 5–7 go to OFF on the next cycle.
- Held requests:
  - start held in READY has no effect.
  - restart held continuously re-enters RST_HOLD only from READY/FAULT. It does not loop once in RST_HOLD or SETTLE.

Test Plan:
1. Bring-up: rst 2 cycles, then start=1, with a real clks instance driven by gen_rst/gen_enb.
   - gen_rst falls 4 cycles after entering RST_HOLD.
   - busy high during RST_HOLD and SETTLE.
   - ready=1 within 45 cycles of gen_enb rising; fault stays 0.
2. Watchdog: from READY, force clk40_mon stuck at 0.
   - fault=1 exactly 64 cycles after the last detected edge.
   - gen_enb=0, gen_rst=1, state=4, ready=0.
3. Recovery: from FAULT, release the force and pulse restart 1 cycle.
   - Path RST_HOLD (4 cycles) -> SETTLE -> READY.
   - fault clears on entry to RST_HOLD.
4. Priority: assert stop and restart in the same READY cycle.
   - Next state OFF, gen_rst=1, ready=0.
   - Repeat with stop on the same cycle as watchdog expiry: next state OFF, fault never set.
5. Reset mid-SETTLE: assert rst 3 cycles after SETTLE entry.
   - Next cycle: state=0, gen_enb=0, busy=0, counter=0.
   - A subsequent start replays the full RST_HOLD sequence.
6. Settle fault: clk40_mon held at 1 from start.
   - SETTLE times out to FAULT after 64 cycles in SETTLE; ready never asserts.

Source files
------------

// File: rtl/clk_seq_ctrl.sv
// Clock divider sequencer: holds the divider in reset, waits for clk40 to toggle,
// then raises ready. A clk40 watchdog shuts the divider down on a stall.
module clk_seq_ctrl #(
    parameter int RST_CYCLES   = 4,
    parameter int SETTLE_EDGES = 2,
    parameter int WDT_CYCLES   = 64,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       restart,
    input  logic       clk40_mon,
    output logic       gen_rst,
    output logic       gen_enb,
    output logic       ready,
    output logic       fault,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_RST_HOLD = 3'd1,
        S_SETTLE   = 3'd2,
        S_READY    = 3'd3,
        S_FAULT    = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);
    localparam logic [3:0]       EDGE_TGT = 4'(SETTLE_EDGES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       ecnt_q, ecnt_d, ecnt_inc;
    logic             mon_q1, mon_q2;
    logic             edge_seen;
    logic             gen_rst_q, gen_rst_d;
    logic             gen_enb_q, gen_enb_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             busy_q, busy_d;

    assign edge_seen = mon_q1 ^ mon_q2;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign ecnt_inc  = ecnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        ecnt_d  = ecnt_q;
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                if (start) state_d = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                if (cnt_q == RST_LAST) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (edge_seen) begin
                    cnt_d  = '0;
                    ecnt_d = ecnt_inc;
                    if (ecnt_inc == EDGE_TGT) state_d = S_READY;
                end else if (cnt_q == WDT_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_READY: begin
                if (restart)             state_d = S_RST_HOLD;
                else if (edge_seen)      cnt_d   = '0;
                else if (cnt_q == WDT_LAST) state_d = S_FAULT;
            end
            S_FAULT: begin
                cnt_d = '0;
                if (restart) state_d = S_RST_HOLD;
            end
            default: state_d = S_OFF;
        endcase
        // stop overrides every other request and the watchdog
        if (stop) state_d = S_OFF;
        if (state_d != state_q) begin
            cnt_d  = '0;
            ecnt_d = '0;
        end
    end

    // outputs decoded from the next state so they move with the state register
    always_comb begin
        gen_rst_d = (state_d == S_OFF) || (state_d == S_RST_HOLD)
                 || (state_d == S_FAULT);
        gen_enb_d = ~gen_rst_d;
        ready_d   = (state_d == S_READY);
        fault_d   = (state_d == S_FAULT);
        busy_d    = (state_d == S_RST_HOLD) || (state_d == S_SETTLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            ecnt_q    <= '0;
            mon_q1    <= 1'b0;
            mon_q2    <= 1'b0;
            gen_rst_q <= 1'b1;
            gen_enb_q <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ecnt_q    <= ecnt_d;
            mon_q1    <= clk40_mon;
            mon_q2    <= mon_q1;
            gen_rst_q <= gen_rst_d;
            gen_enb_q <= gen_enb_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            busy_q    <= busy_d;
        end
    end

    assign gen_rst = gen_rst_q;
    assign gen_enb = gen_enb_q;
    assign ready   = ready_q;
    assign fault   = fault_q;
    assign busy    = busy_q;
    assign state   = state_q;

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// Bench for clk_seq_ctrl: vector table through a scoreboard queue, then
// bring-up, watchdog, recovery, priority, mid-reset and settle-fault sequences.
module tb_clk_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, restart;
    logic       clk40_mon;
    logic       gen_rst, gen_enb, ready, fault, busy;
    logic [2:0] state;

    logic       mon_sel, mon_val;
    logic [2:0] div_cnt;
    logic       div_clk40;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // divider stand-in: clk40 toggles every 8 fast cycles while enabled
    always @(posedge clk) begin
        if (gen_rst !== 1'b0 || gen_enb !== 1'b1) begin
            div_cnt   <= '0;
            div_clk40 <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 3'd1;
            if (div_cnt == 3'd7) div_clk40 <= ~div_clk40;
        end
    end

    assign clk40_mon = mon_sel ? mon_val : div_clk40;

    clk_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .restart   (restart),
        .clk40_mon (clk40_mon),
        .gen_rst   (gen_rst),
        .gen_enb   (gen_enb),
        .ready     (ready),
        .fault     (fault),
        .busy      (busy),
        .state     (state)
    );

    typedef logic [7:0] obs_t;

    typedef struct {
        logic st;
        logic sp;
        logic rs;
        logic mon;
        obs_t exp;
    } vec_t;

    function automatic obs_t mk(input logic [2:0] s, input logic gr,
                                input logic ge, input logic rd,
                                input logic ft, input logic bz);
        return {s, gr, ge, rd, ft, bz};
    endfunction

    function automatic obs_t obs();
        return {state, gen_rst, gen_enb, ready, fault, busy};
    endfunction

    localparam obs_t O_OFF = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam obs_t O_RH  = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam obs_t O_SE  = {3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam obs_t O_RD  = {3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam obs_t O_FT  = {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic count_state(input logic [2:0] s, input int lim,
                               output int n);
        n = 0;
        while (state == s && n < lim) begin
            n++;
            tick();
        end
    endtask

    vec_t vt[15];
    obs_t sb_q[$];

    initial begin
        int   n;
        logic flag;
        obs_t e;

        rst = 1'b1; start = 0; stop = 0; restart = 0;
        mon_sel = 1'b1; mon_val = 1'b0;

        vt[0]  = '{0, 0, 0, 0, O_OFF};
        vt[1]  = '{1, 0, 0, 0, O_RH};
        vt[2]  = '{0, 0, 0, 0, O_RH};
        vt[3]  = '{0, 0, 0, 0, O_RH};
        vt[4]  = '{0, 0, 0, 0, O_RH};
        vt[5]  = '{0, 0, 0, 0, O_SE};
        vt[6]  = '{0, 0, 0, 1, O_SE};
        vt[7]  = '{0, 0, 0, 1, O_SE};
        vt[8]  = '{0, 0, 0, 0, O_SE};
        vt[9]  = '{0, 0, 0, 0, O_RD};
        vt[10] = '{1, 0, 0, 0, O_RD};
        vt[11] = '{0, 0, 1, 0, O_RH};
        vt[12] = '{0, 0, 1, 0, O_RH};
        vt[13] = '{0, 1, 1, 0, O_OFF};
        vt[14] = '{1, 1, 0, 0, O_OFF};

        do_reset();
        check("reset_state", obs(), O_OFF);

        for (int i = 0; i < 15; i++) begin
            start   = vt[i].st;
            stop    = vt[i].sp;
            restart = vt[i].rs;
            mon_val = vt[i].mon;
            sb_q.push_back(vt[i].exp);
            tick();
            e = sb_q.pop_front();
            check($sformatf("vec%0d", i), obs(), e);
        end
        start = 0; stop = 0; restart = 0;

        // bring-up against the divider model
        mon_sel = 1'b0;
        do_reset();
        start = 1'b1;
        tick();
        check("bringup_enter_rh", obs(), O_RH);
        flag = 1'b1;
        n = 0;
        while (state == 3'd1 && n < 20) begin
            flag &= busy;
            n++;
            tick();
        end
        check("bringup_rh_dwell", n, 4);
        check("bringup_settle", obs(), O_SE);
        n = 0;
        while (!ready && n < 60) begin
            flag &= busy & ~fault;
            n++;
            tick();
        end
        check("bringup_ready_in_45", (ready && n <= 45), 1);
        check("bringup_busy_no_fault", flag, 1);
        check("bringup_ready_outs", obs(), O_RD);
        start = 1'b0;

        // watchdog: last edge is detected 2 cycles after mon drops
        mon_sel = 1'b1;
        mon_val = 1'b1;
        repeat (4) tick();
        mon_val = 1'b0;
        n = 0;
        while (!fault && n < 100) begin
            tick();
            n++;
        end
        check("wdt_cycles_from_drop", n, 66);
        check("wdt_fault_outs", obs(), O_FT);

        // recovery
        mon_sel = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("recover_rh_fault_clr", obs(), O_RH);
        count_state(3'd1, 20, n);
        check("recover_rh_dwell", n, 4);
        check("recover_settle", obs(), O_SE);
        count_state(3'd2, 60, n);
        check("recover_ready", obs(), O_RD);

        // stop beats restart
        stop = 1'b1;
        restart = 1'b1;
        tick();
        stop = 1'b0;
        restart = 1'b0;
        check("stop_vs_restart", obs(), O_OFF);

        // stop on the watchdog terminal cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        count_state(3'd1, 20, n);
        count_state(3'd2, 60, n);
        check("prio_reach_ready", obs(), O_RD);
        mon_sel = 1'b1;
        mon_val = 1'b1;
        repeat (4) tick();
        mon_val = 1'b0;
        flag = 1'b0;
        repeat (65) begin
            tick();
            flag |= fault;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        flag |= fault;
        check("stop_vs_wdt_off", obs(), O_OFF);
        check("stop_vs_wdt_no_fault", flag, 0);

        // reset three cycles into SETTLE
        start = 1'b1;
        tick();
        start = 1'b0;
        count_state(3'd1, 20, n);
        check("midrst_settle", obs(), O_SE);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_off", obs(), O_OFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrst_replay_rh", obs(), O_RH);
        count_state(3'd1, 20, n);
        check("midrst_replay_dwell", n, 4);

        // clk40 stuck high from start: settle times out
        mon_val = 1'b1;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        count_state(3'd1, 20, n);
        flag = 1'b0;
        n = 0;
        while (state == 3'd2 && n < 100) begin
            flag |= ready;
            n++;
            tick();
        end
        check("settle_timeout_cycles", n, 64);
        check("settle_timeout_fault", obs(), O_FT);
        check("settle_never_ready", flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
